regfile_dump_reader: RTL

- Readback engine for the 32x32 register file.
- On a start pulse it walks an address range through one regfile read port and streams each register value out on a valid/ready interface, tagging the last beat.
- Used for bring-up dumps and self-check: software or a test sequencer writes the regfile, and this block reads it back.
- Sits beside the regfile and owns one read port (A or B) while busy.

---
 rtl/regfile_dump_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Purpose:
//   Readback engine for the register file. A start pulse latches an address
//   range. The block then walks that range through one regfile read port and
//   streams each register value out over a valid/ready interface. The final
//   beat of the dump is tagged with out_last.
//
// Optional feature (compile-time macro DUMP_CHECKSUM_EN):
//   When the macro is defined, a DATA_W running sum of the accepted data beats
//   is kept. After the last data beat, one extra beat carries that sum, with
//   out_addr=0 and out_last=1.
//
// Ports:
//   clock         rising-edge clock
//   ctrl_reset_n  asynchronous active-low reset
//   start         one-cycle request, sampled only in IDLE
//   start_addr    first register of the range (sampled with start)
//   end_addr      last register of the range (sampled with start)
//   abort         synchronous cancel while READ or PRESENT
//   ctrl_readReg  address to the regfile read port
//   data_readReg  combinational read data from the regfile
//   out_data      stream data
//   out_addr      register index of the current beat
//   out_valid     beat available
//   out_ready     consumer accepts when out_valid & out_ready at an edge
//   out_last      final beat of the dump
//   busy          high in every state except IDLE
//   done          one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] last_ptr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;

  // The pointer wraps naturally at 2**ADDR_W, which is how wrapped ranges
  // such as 30,31,0,1 are walked.
  logic [ADDR_W-1:0] ptr_inc_d;
  assign ptr_inc_d = ptr_q + 1'b1;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;
  assign sum_d = sum_q + data_q;
`endif

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      last_ptr_q <= '0;
      rd_addr_q  <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ptr_q      <= start_addr;
            last_ptr_q <= end_addr;
            rd_addr_q  <= start_addr;
`ifdef DUMP_CHECKSUM_EN
            sum_q      <= '0;
`endif
            state_q    <= READ;
          end
        end

        READ: begin
          if (abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // The read port is combinational, so data for rd_addr_q is
            // already valid in this cycle.
            data_q  <= data_readReg;
            addr_q  <= ptr_q;
            valid_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            last_q  <= 1'b0;  // the checksum beat is the one tagged last
`else
            last_q  <= (ptr_q == last_ptr_q);
`endif
            state_q <= PRESENT;
          end
        end

        PRESENT: begin
          // Abort takes priority over a simultaneous accept.
          if (abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= IDLE;
          end else if (out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              sum_q <= sum_d;
              if (ptr_q == last_ptr_q) begin
                // Replace the accepted data beat with the checksum beat.
                // out_valid stays high.
                data_q <= sum_d;
                addr_q <= '0;
                last_q <= 1'b1;
              end else begin
                ptr_q     <= ptr_inc_d;
                rd_addr_q <= ptr_inc_d;
                valid_q   <= 1'b0;
                state_q   <= READ;
              end
`else
              ptr_q     <= ptr_inc_d;
              rd_addr_q <= ptr_inc_d;
              valid_q   <= 1'b0;
              state_q   <= READ;
`endif
            end
          end
        end

        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_readReg = rd_addr_q;
  assign out_data     = data_q;
  assign out_addr     = addr_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);

endmodule
